gtfmac_vnc_tx_gtfmac_if: RTL

GTFMAC_VNC_TX_GTFMAC_IF -- requirements
Module: gtfmac_vnc_tx_gtfmac_if

---
 rtl/gtfmac_vnc_tx_gtfmac_if.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/gtfmac_vnc_tx_gtfmac_if.sv
// Transmit adapter between the VNC packet-word generator and the GTF MAC AXIS
// transmit port. Incoming 64-bit packet words are buffered in a small FIFO.
// A four-state FSM turns them into MAC beats:
//   - a preamble phase (one 64-bit beat at 25G, four 16-bit beats at 10G),
//   - data beats,
//   - an optional trailing "late" end marker.
//
// Output handshake: every MAC-side output is a flop. A beat, once presented,
// stays frozen until tx_axis_tready=1 is seen on a rising edge. This holds
// whether or not tx_axis_tvalid is 1, because preamble and late beats carry
// tvalid=0. Idle cycles (nothing presented) need no tready. A new beat is
// computed whenever the output register is empty or is being accepted.
module gtfmac_vnc_tx_gtfmac_if #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        tx_axis_clk,
  input  logic        tx_axis_rst_n,
  input  logic        ctl_tx_data_rate,
  input  logic        ctl_tx_custom_preamble_en,
  input  logic        din_ena,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_err,
  input  logic        din_empty,
  input  logic [63:0] din_data,
  input  logic [2:0]  din_mty,
  output logic        din_rdy,
  input  logic        tx_axis_tready,
  output logic        tx_axis_tvalid,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tpre,
  output logic [7:0]  tx_axis_tlast,
  output logic        tx_axis_terr,
  output logic        tx_axis_tsof,
  output logic        stat_underflow,
  output logic        stat_dropped_empty,
  output logic        stat_overflow,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [63:0] STD_PREAMBLE = 64'hD555_5555_5555_55FB;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_LATE} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mty;
    logic        err;
  } word_t;

  // ---------------------------------------------------------------- FIFO
  word_t       mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic        fifo_full, fifo_empty, full_n;
  logic        push, pop, drop_empty, overflow;
  word_t       head, word_in;

  assign word_in    = '{data: din_data, sop: din_sop, eop: din_eop, mty: din_mty, err: din_err};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Zero-length words are discarded before they reach the buffer. A push
  // into a full buffer is lost even if a pop happens in the same cycle.
  assign drop_empty = din_ena && din_sop && din_eop && din_empty;
  assign overflow   = din_ena && !drop_empty && fifo_full;
  assign push       = din_ena && !drop_empty && !fifo_full;

  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
  assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  // Buffer storage; contents need no reset because the pointers gate them.
  always_ff @(posedge tx_axis_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_in;
  end

  // Pointers, ready flag, and the input-side status pulses.
  // din_rdy is held low during reset.
  always_ff @(posedge tx_axis_clk or negedge tx_axis_rst_n) begin
    if (!tx_axis_rst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      din_rdy            <= 1'b0;
      stat_overflow      <= 1'b0;
      stat_dropped_empty <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr_n;
      rd_ptr             <= rd_ptr_n;
      din_rdy            <= !full_n;
      stat_overflow      <= overflow;
      stat_dropped_empty <= drop_empty;
    end
  end

  // ----------------------------------------------------------------- FSM
  state_t      state, state_n;
  logic [1:0]  beat_cnt, beat_cnt_n;
  logic [63:0] pre_word, pre_word_n;
  logic        late_err, late_err_n;
  logic        seen_first, seen_first_n;
  logic        uf_flag, uf_flag_n;
  logic        uf_pulse;
  logic        out_vld, out_vld_n;
  logic        load;

  logic        tvalid_n, terr_n, tsof_n;
  logic [63:0] tdata_n;
  logic [7:0]  tpre_n, tlast_n;

  // nm1 is (valid bytes - 1) of the head word, 0..7. At 10G the terminating
  // beat index is nm1/2, and an odd byte count leaves that beat half full.
  logic [2:0]  nm1;
  logic [1:0]  last_k;

  assign nm1       = 3'd7 - head.mty;
  assign last_k    = nm1[2:1];
  assign load      = !out_vld || tx_axis_tready;
  assign dbg_state = state;

  function automatic logic [15:0] slice16(input logic [63:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[15:0];
      2'd1:    return w[31:16];
      2'd2:    return w[47:32];
      default: return w[63:48];
    endcase
  endfunction

  // Next state, FIFO pop, and the next beat to present.
  // When not loading, every output-register input holds its current value.
  always_comb begin
    state_n      = state;
    beat_cnt_n   = beat_cnt;
    pre_word_n   = pre_word;
    late_err_n   = late_err;
    seen_first_n = seen_first;
    uf_flag_n    = uf_flag;
    uf_pulse     = 1'b0;
    pop          = 1'b0;
    out_vld_n    = out_vld;
    tvalid_n     = tx_axis_tvalid;
    tdata_n      = tx_axis_tdata;
    tpre_n       = tx_axis_tpre;
    tlast_n      = tx_axis_tlast;
    terr_n       = tx_axis_terr;
    tsof_n       = tx_axis_tsof;

    if (load) begin
      // Default is an idle cycle: nothing presented, all outputs zero.
      out_vld_n = 1'b0;
      tvalid_n  = 1'b0;
      tdata_n   = '0;
      tpre_n    = '0;
      tlast_n   = '0;
      terr_n    = 1'b0;
      tsof_n    = 1'b0;

      case (state)
        S_IDLE: begin
          if (!fifo_empty && head.sop) begin
            state_n    = S_PRE;
            beat_cnt_n = 2'd0;
            uf_flag_n  = 1'b0;
            // With a custom preamble the SOP word is consumed as the
            // preamble, so any later SOP in DATA means a new frame.
            seen_first_n = ctl_tx_custom_preamble_en;
            if (ctl_tx_custom_preamble_en) begin
              pre_word_n = head.data;
              pop        = 1'b1;
            end else begin
              pre_word_n = STD_PREAMBLE;
            end
          end else if (!fifo_empty) begin
            // A word with no frame to belong to would block the buffer.
            pop = 1'b1;
          end
        end

        S_PRE: begin
          out_vld_n = 1'b1;
          if (ctl_tx_data_rate) begin
            tdata_n    = pre_word;
            tpre_n     = 8'hFF;
            tsof_n     = 1'b1;
            state_n    = S_DATA;
            beat_cnt_n = 2'd0;
          end else begin
            tdata_n = {48'd0, slice16(pre_word, beat_cnt)};
            tpre_n  = 8'h03;
            tsof_n  = (beat_cnt == 2'd0);
            if (beat_cnt == 2'd3) begin
              state_n    = S_DATA;
              beat_cnt_n = 2'd0;
            end else begin
              beat_cnt_n = beat_cnt + 2'd1;
            end
          end
        end

        S_DATA: begin
          if (fifo_empty) begin
            if (!uf_flag) begin
              uf_pulse  = 1'b1;
              uf_flag_n = 1'b1;
            end
          end else if (beat_cnt == 2'd0 && head.sop && seen_first) begin
            // The previous frame never saw its EOP. Close it as errored;
            // the SOP word stays in the buffer for the next frame.
            late_err_n = 1'b1;
            state_n    = S_LATE;
          end else begin
            out_vld_n = 1'b1;
            tvalid_n  = 1'b1;
            if (ctl_tx_data_rate) begin
              tdata_n      = head.data;
              pop          = 1'b1;
              seen_first_n = 1'b1;
              if (head.eop) begin
                if (head.mty != 3'd0) begin
                  tlast_n = 8'h02 << nm1;
                  terr_n  = head.err;
                  state_n = S_IDLE;
                end else begin
                  late_err_n = head.err;
                  state_n    = S_LATE;
                end
              end
            end else begin
              tdata_n = {48'd0, slice16(head.data, beat_cnt)};
              if (head.eop && beat_cnt == last_k) begin
                pop          = 1'b1;
                seen_first_n = 1'b1;
                beat_cnt_n   = 2'd0;
                if (!nm1[0]) begin
                  tlast_n = 8'h02;
                  terr_n  = head.err;
                  state_n = S_IDLE;
                end else begin
                  late_err_n = head.err;
                  state_n    = S_LATE;
                end
              end else if (beat_cnt == 2'd3) begin
                pop          = 1'b1;
                seen_first_n = 1'b1;
                beat_cnt_n   = 2'd0;
              end else begin
                beat_cnt_n = beat_cnt + 2'd1;
              end
            end
          end
        end

        default: begin  // S_LATE
          out_vld_n  = 1'b1;
          tlast_n    = 8'h01;
          terr_n     = late_err;
          late_err_n = 1'b0;
          beat_cnt_n = 2'd0;
          state_n    = S_IDLE;
        end
      endcase
    end
  end

  // FSM state, frame bookkeeping, and the registered MAC-side outputs.
  always_ff @(posedge tx_axis_clk or negedge tx_axis_rst_n) begin
    if (!tx_axis_rst_n) begin
      state          <= S_IDLE;
      beat_cnt       <= 2'd0;
      pre_word       <= '0;
      late_err       <= 1'b0;
      seen_first     <= 1'b0;
      uf_flag        <= 1'b0;
      out_vld        <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tpre   <= '0;
      tx_axis_tlast  <= '0;
      tx_axis_terr   <= 1'b0;
      tx_axis_tsof   <= 1'b0;
      stat_underflow <= 1'b0;
    end else begin
      state          <= state_n;
      beat_cnt       <= beat_cnt_n;
      pre_word       <= pre_word_n;
      late_err       <= late_err_n;
      seen_first     <= seen_first_n;
      uf_flag        <= uf_flag_n;
      out_vld        <= out_vld_n;
      tx_axis_tvalid <= tvalid_n;
      tx_axis_tdata  <= tdata_n;
      tx_axis_tpre   <= tpre_n;
      tx_axis_tlast  <= tlast_n;
      tx_axis_terr   <= terr_n;
      tx_axis_tsof   <= tsof_n;
      stat_underflow <= uf_pulse;
    end
  end

endmodule
